uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command sequencer that sits directly behind the `uart` receiver. It consumes the `received` strobe and `rx_byte`, and parses 4-byte framed commands: SYNC, CMD, DATA, SUM. Valid write commands update a 4x8 configuration register bank that drives the rest of the tile. On framing, checksum or timeout errors it holds the receiver in reset for a resync window, then resumes hunting for SYNC.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 400, max clk cycles allowed between bytes inside a frame (about 2 byte times at 6 kHz / 300 baud).
- RESYNC_CYCLES, 40, clk cycles `uart_rst` is held after an error.
- CNT_W, 9, width of the shared timeout/resync counter; must satisfy 2^CNT_W > max(TIMEOUT_CYCLES, RESYNC_CYCLES).

Ports:
- clk, input, 1, master clock.
- rst, input, 1, reset; asynchronous, active-high.
- received, input, 1, one-cycle byte-valid strobe from the `uart` receiver.
- rx_byte, input, 8, received byte; sampled only when `received`=1.
- uart_rst, output, 1, synchronous reset driven to the `uart` receiver.
- cfg, output, 32, register bank; reg N occupies bits [8N+7:8N].
- wr_pulse, output, 1, one-cycle strobe when a register is written.
- frame_err, output, 1, one-cycle strobe on any frame rejection.
- busy, output, 1, high whenever the state is not HUNT.
- ok_count, output, 8, count of accepted frames; saturates at 255.

Behaviour:
- Reset values: state HUNT; `cfg`=0; `ok_count`=0; counter=0; `wr_pulse`=0; `frame_err`=0; `uart_rst`=1 while `rst` is high, 0 after release.
- All outputs are registered. `wr_pulse` and `frame_err` are never high in the same cycle.
- States:
  - HUNT: on `received`, if `rx_byte`==SYNC_BYTE go to GET_CMD and clear the counter; any other byte is silently dropped and the state stays HUNT. No timeout is active in HUNT.
  - GET_CMD: on `received`, latch cmd and go to GET_DATA.
  - GET_DATA: on `received`, latch data and go to GET_SUM.
  - GET_SUM: on `received`, compare `rx_byte` against (cmd+data) mod 256, keeping 8 bits and discarding the carry.
    - Match and cmd[7:6]==2'b01: write `cfg[cmd[1:0]]`=data, pulse `wr_pulse`.
    - Match and cmd[7:6]==2'b00 (NOP): no write.
    - In both match cases: increment `ok_count` (saturating), return to HUNT.
    - Mismatch, or cmd[7:6] in {10, 11}: go to ERROR.
  - ERROR: pulse `frame_err` for 1 cycle, load counter=RESYNC_CYCLES, go to RESYNC.
  - RESYNC: `uart_rst`=1; decrement the counter each cycle; at 0 drop `uart_rst` and go to HUNT. Any `received` seen in RESYNC is ignored.
- The `cfg` write and the `wr_pulse` assertion occur on the same clk edge that samples the SUM byte. `cfg` is visible on the next cycle.
- Timeout (GET_CMD, GET_DATA, GET_SUM only):
  - The counter increments each cycle and clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES with no byte, go to ERROR.
  - If `received` arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the byte wins and the timeout is discarded.
- A SYNC_BYTE value received inside a frame is treated as ordinary data; there is no mid-frame resync.
- Asserting `rst` mid-frame aborts the frame immediately, clears `cfg`, and produces no `frame_err` pulse.
- Counter arithmetic is unsigned CNT_W bits and never wraps, because each state reloads or clears it.

Decomposition:
- Shared package `uart_cmd_pkg` holds:
  - the state enum: HUNT, GET_CMD, GET_DATA, GET_SUM, ERROR, RESYNC;
  - the CMD opcode constants: OP_NOP=2'b00, OP_WR=2'b01;
  - SYNC_BYTE.
- One sub-module is natural: `cmd_timer`, which provides the CNT_W-bit counter with clear, load and decrement, plus a terminal flag. It is shared by the timeout and resync logic.
- The `uart` receiver is instantiated by the parent, not inside this block.

Test Plan:
1. Bytes A5, 42, 3C, 7E (0x42+0x3C=0x7E) -> `wr_pulse` for 1 cycle; `cfg`[23:16]=3C; `ok_count`=1; `busy` returns to 0.
2. Bytes A5, 41, 10, 00 (bad sum) -> no write; `frame_err` for 1 cycle; `uart_rst` high for exactly 40 cycles; `cfg` unchanged.
3. Bytes 00, FF, A5, 00, 55, 55 (junk, then a NOP frame) -> junk is dropped; no write; `ok_count` increments; `frame_err` stays 0.
4. A5, 41, then 401 idle cycles -> `frame_err` exactly 400 cycles after byte 41, then resync; a following good frame A5, 40, 01, 41 -> `cfg`[7:0]=01.
5. A5, C0, 00, C0 (reserved opcode with a correct sum) -> `frame_err` pulses; no write.
6. `rst` asserted after A5, 43 of a frame, mid-cycle between clock edges -> `busy`=0 immediately (asynchronous); `cfg`=0 and `ok_count`=0; no `frame_err`; the next good frame is accepted; 256 good NOP frames -> `ok_count` holds at 255.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: frame marker,
// opcode values, state encoding and the frame checksum helper.
package uart_cmd_pkg;

  // Frame start marker.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Opcode field values (cmd[7:6]); 2'b10 and 2'b11 are reserved.
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;

  // Sequencer states, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_HUNT     = 3'd0;
  localparam state_t ST_GET_CMD  = 3'd1;
  localparam state_t ST_GET_DATA = 3'd2;
  localparam state_t ST_GET_SUM  = 3'd3;
  localparam state_t ST_ERROR    = 3'd4;
  localparam state_t ST_RESYNC   = 3'd5;

  // Layout of the CMD byte.
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] rsvd;
    logic [1:0] addr;
  } cmd_t;

  // Frame checksum: 8-bit sum of CMD and DATA, carry discarded.
  function automatic logic [7:0] frame_sum(input logic [7:0] cmd, input logic [7:0] data);
    logic [8:0] full;
    full = {1'b0, cmd} + {1'b0, data};
    return full[7:0];
  endfunction

  // Only NOP and WRITE opcodes are accepted.
  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_NOP) || (op == OP_WR);
  endfunction

endpackage

// File: rtl/cmd_timer.sv
// Shared counter for the inter-byte timeout and the resync hold window.
// Clear has priority over load, load over decrement, decrement over
// increment; the count saturates at both ends instead of wrapping.
module cmd_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Counter register with prioritised clear / load / step controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == CNT_ZERO);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer behind the UART receiver. Parses SYNC/CMD/DATA/SUM
// frames, writes a 4x8 configuration bank on valid WRITE commands, and
// holds the receiver in reset for a resync window after any rejection.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 400,
  parameter int RESYNC_CYCLES  = 40,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  output logic        uart_rst,
  output logic [31:0] cfg,
  output logic        wr_pulse,
  output logic        frame_err,
  output logic        busy,
  output logic [7:0]  ok_count
);

  // The timeout fires on the edge where the counter would reach
  // TIMEOUT_CYCLES, so ERROR (and frame_err) appear exactly
  // TIMEOUT_CYCLES edges after the last accepted byte.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESYNC_LOAD  = CNT_W'(RESYNC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_state_s;
  cmd_t             cmd_r;
  logic [7:0]       data_r;
  logic [3:0][7:0]  cfg_r;
  logic [7:0]       ok_count_r;
  logic             uart_rst_r;
  logic             wr_pulse_r;
  logic             frame_err_r;
  logic             busy_r;

  logic             tmr_clr_s;
  logic             tmr_load_s;
  logic             tmr_inc_s;
  logic             tmr_dec_s;
  logic [CNT_W-1:0] tmr_count_s;
  logic             tmr_zero_s;

  logic             take_cmd_s;
  logic             take_data_s;
  logic             accept_s;
  logic             write_s;
  logic             timeout_s;
  logic             sum_ok_s;

  cmd_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr_s),
    .load     (tmr_load_s),
    .inc      (tmr_inc_s),
    .dec      (tmr_dec_s),
    .load_val (RESYNC_LOAD),
    .count    (tmr_count_s),
    .zero     (tmr_zero_s)
  );

  assign timeout_s = (tmr_count_s == TIMEOUT_LAST);
  assign sum_ok_s  = (frame_sum(cmd_r, data_r) == rx_byte);

  // Next-state and datapath control decode.
  always_comb begin
    next_state_s = state_r;
    tmr_clr_s    = 1'b0;
    tmr_load_s   = 1'b0;
    tmr_inc_s    = 1'b0;
    tmr_dec_s    = 1'b0;
    take_cmd_s   = 1'b0;
    take_data_s  = 1'b0;
    accept_s     = 1'b0;
    write_s      = 1'b0;
    case (state_r)
      ST_HUNT: begin
        if (received && (rx_byte == SYNC_BYTE)) begin
          next_state_s = ST_GET_CMD;
          tmr_clr_s    = 1'b1;
        end else begin
          next_state_s = ST_HUNT;
        end
      end
      ST_GET_CMD: begin
        if (received) begin
          take_cmd_s   = 1'b1;
          tmr_clr_s    = 1'b1;
          next_state_s = ST_GET_DATA;
        end else if (timeout_s) begin
          next_state_s = ST_ERROR;
        end else begin
          tmr_inc_s    = 1'b1;
        end
      end
      ST_GET_DATA: begin
        if (received) begin
          take_data_s  = 1'b1;
          tmr_clr_s    = 1'b1;
          next_state_s = ST_GET_SUM;
        end else if (timeout_s) begin
          next_state_s = ST_ERROR;
        end else begin
          tmr_inc_s    = 1'b1;
        end
      end
      ST_GET_SUM: begin
        if (received) begin
          tmr_clr_s = 1'b1;
          if (sum_ok_s && op_is_valid(cmd_r.op)) begin
            accept_s     = 1'b1;
            write_s      = (cmd_r.op == OP_WR);
            next_state_s = ST_HUNT;
          end else begin
            next_state_s = ST_ERROR;
          end
        end else if (timeout_s) begin
          next_state_s = ST_ERROR;
        end else begin
          tmr_inc_s    = 1'b1;
        end
      end
      ST_ERROR: begin
        tmr_load_s   = 1'b1;
        next_state_s = ST_RESYNC;
      end
      ST_RESYNC: begin
        // Leaving on a count of one makes the hold exactly RESYNC_CYCLES long.
        if (tmr_zero_s || (tmr_count_s == CNT_ONE)) begin
          tmr_clr_s    = 1'b1;
          next_state_s = ST_HUNT;
        end else begin
          tmr_dec_s    = 1'b1;
          next_state_s = ST_RESYNC;
        end
      end
      default: begin
        tmr_clr_s    = 1'b1;
        next_state_s = ST_HUNT;
      end
    endcase
  end

  // State register and registered status strobes derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_HUNT;
      busy_r      <= 1'b0;
      uart_rst_r  <= 1'b1;
      wr_pulse_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != ST_HUNT);
      uart_rst_r  <= (next_state_s == ST_RESYNC);
      wr_pulse_r  <= write_s;
      frame_err_r <= (next_state_s == ST_ERROR);
    end
  end

  // Capture CMD and DATA bytes of the frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_r  <= '{op: 2'b00, rsvd: 4'h0, addr: 2'b00};
      data_r <= 8'h00;
    end else begin
      if (take_cmd_s) begin
        cmd_r <= cmd_t'(rx_byte);
      end else begin
        cmd_r <= cmd_r;
      end
      if (take_data_s) begin
        data_r <= rx_byte;
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Configuration bank write on the edge that accepts the SUM byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_r <= 32'h0000_0000;
    end else if (write_s) begin
      cfg_r[cmd_r.addr] <= data_r;
    end else begin
      cfg_r <= cfg_r;
    end
  end

  // Saturating count of accepted frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_count_r <= 8'h00;
    end else if (accept_s && (ok_count_r != 8'hFF)) begin
      ok_count_r <= ok_count_r + 8'h01;
    end else begin
      ok_count_r <= ok_count_r;
    end
  end

  assign uart_rst  = uart_rst_r;
  assign cfg       = cfg_r;
  assign wr_pulse  = wr_pulse_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;
  assign ok_count  = ok_count_r;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: a vector table of whole frames,
// hand-written timing sequences, and random traffic compared each cycle
// against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int TIMEOUT = 400;
  localparam int RESYNC  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        received;
  logic [7:0]  rx_byte;
  logic        uart_rst;
  logic [31:0] cfg;
  logic        wr_pulse;
  logic        frame_err;
  logic        busy;
  logic [7:0]  ok_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .RESYNC_CYCLES (RESYNC),
    .CNT_W         (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .received  (received),
    .rx_byte   (rx_byte),
    .uart_rst  (uart_rst),
    .cfg       (cfg),
    .wr_pulse  (wr_pulse),
    .frame_err (frame_err),
    .busy      (busy),
    .ok_count  (ok_count)
  );

  // ---------------- reference model (frame-position view) ----------------
  int         m_pos;        // 0 = hunting, 1..3 = next expected frame byte
  int         m_idle;       // idle cycles since last in-frame byte
  int         m_resync;     // remaining cycles of receiver hold
  bit         m_err_cycle;  // the one-cycle rejection slot
  int         m_ok;
  int         m_frame [3];
  int         m_cfg [4];
  bit         m_wr;
  bit         m_err;

  function automatic void model_reset();
    m_pos = 0; m_idle = 0; m_resync = 0; m_err_cycle = 0; m_ok = 0;
    m_wr = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_cfg[i] = 0;
  endfunction

  function automatic void model_step(input logic rcv, input logic [7:0] b);
    int c, d, s;
    m_wr = 0; m_err = 0;
    if (m_err_cycle) begin
      m_err_cycle = 0;
      m_resync = RESYNC;
    end else if (m_resync > 0) begin
      m_resync--;
    end else if (m_pos == 0) begin
      if (rcv && b == 8'hA5) begin m_pos = 1; m_idle = 0; end
    end else if (rcv) begin
      m_frame[m_pos-1] = int'(b);
      m_idle = 0;
      if (m_pos < 3) begin
        m_pos++;
      end else begin
        m_pos = 0;
        c = m_frame[0]; d = m_frame[1]; s = m_frame[2];
        if (((c + d) % 256) == s && (c / 64) < 2) begin
          if (m_ok < 255) m_ok++;
          if ((c / 64) == 1) begin m_cfg[c % 4] = d; m_wr = 1; end
        end else begin
          m_err = 1; m_err_cycle = 1;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin m_pos = 0; m_err = 1; m_err_cycle = 1; end
    end
  endfunction

  function automatic logic [52:0] model_outputs();
    logic [31:0] c;
    c = {m_cfg[3][7:0], m_cfg[2][7:0], m_cfg[1][7:0], m_cfg[0][7:0]};
    return {m_resync > 0, (m_pos != 0) || m_err_cycle || (m_resync > 0),
            m_wr, m_err, 8'(m_ok), c, 9'd0};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, step the model, sample #1 after the edge.
  task automatic cycle(input logic rcv, input logic [7:0] b);
    received = rcv;
    rx_byte  = b;
    @(posedge clk);
    model_step(rcv, b);
    #1;
    received = 1'b0;
    check("model {uart_rst,busy,wr,err,ok,cfg}",
          64'({uart_rst, busy, wr_pulse, frame_err, ok_count, cfg, 9'd0}),
          64'(model_outputs()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input int gap);
    cycle(1'b1, b0); idle(gap);
    cycle(1'b1, b1); idle(gap);
    cycle(1'b1, b2); idle(gap);
    cycle(1'b1, b3);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic [47:0] b;      // bytes, first byte in the top octet
    logic        wr;
    logic        err;
    logic [31:0] cfg;
    logic [7:0]  ok;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_rst, cnt_err, found_at;
    logic [7:0] c, d, s;
    int kind;

    vecs[0] = '{4, 48'hA5423C7E0000, 1'b1, 1'b0, 32'h003C0000, 8'd1};
    vecs[1] = '{4, 48'hA54110000000, 1'b0, 1'b1, 32'h003C0000, 8'd1};
    vecs[2] = '{6, 48'h00FFA5005555, 1'b0, 1'b0, 32'h003C0000, 8'd2};
    vecs[3] = '{4, 48'hA5C000C00000, 1'b0, 1'b1, 32'h003C0000, 8'd2};
    vecs[4] = '{4, 48'hA543FF420000, 1'b1, 1'b0, 32'hFF3C0000, 8'd3};
    vecs[5] = '{4, 48'hA540A5E50000, 1'b1, 1'b0, 32'hFF3C00A5, 8'd4};
    vecs[6] = '{4, 48'hA58100810000, 1'b0, 1'b1, 32'hFF3C00A5, 8'd4};
    vecs[7] = '{4, 48'hA50210120000, 1'b0, 1'b0, 32'hFF3C00A5, 8'd5};

    // Reset state.
    rst = 1'b1; received = 1'b0; rx_byte = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset uart_rst", 64'(uart_rst), 64'(1'b1));
    check("reset busy", 64'(busy), 64'(1'b0));
    check("reset cfg", 64'(cfg), 64'(32'h0));
    check("reset ok_count", 64'(ok_count), 64'(8'h0));
    check("reset strobes", 64'({wr_pulse, frame_err}), 64'(2'b00));
    rst = 1'b0;
    idle(2);
    check("post-reset uart_rst", 64'(uart_rst), 64'(1'b0));

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < vecs[i].n; k++) cycle(1'b1, vecs[i].b[47-8*k -: 8]);
      check($sformatf("vec%0d wr_pulse", i), 64'(wr_pulse), 64'(vecs[i].wr));
      check($sformatf("vec%0d frame_err", i), 64'(frame_err), 64'(vecs[i].err));
      idle(1);
      check($sformatf("vec%0d strobes low", i), 64'({wr_pulse, frame_err}), 64'(2'b00));
      check($sformatf("vec%0d cfg", i), 64'(cfg), 64'(vecs[i].cfg));
      check($sformatf("vec%0d ok_count", i), 64'(ok_count), 64'(vecs[i].ok));
      idle(45);
      check($sformatf("vec%0d idle", i), 64'({busy, uart_rst}), 64'(2'b00));
    end

    // Bad checksum: uart_rst held exactly RESYNC cycles, one frame_err.
    send4(8'hA5, 8'h41, 8'h10, 8'h00, 0);
    check("badsum frame_err", 64'(frame_err), 64'(1'b1));
    cnt_rst = 0; cnt_err = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      if (uart_rst) cnt_rst++;
      if (frame_err) cnt_err++;
    end
    check("badsum uart_rst width", 64'(cnt_rst), 64'(RESYNC));
    check("badsum extra frame_err", 64'(cnt_err), 64'(0));
    check("badsum cfg kept", 64'(cfg), 64'(32'hFF3C00A5));

    // Timeout: frame_err exactly TIMEOUT edges after the CMD byte.
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h41);
    found_at = -1;
    for (int t = 1; t <= 450 && found_at < 0; t++) begin
      idle(1);
      if (frame_err) found_at = t;
    end
    check("timeout latency", 64'(found_at), 64'(TIMEOUT));
    idle(45);
    send4(8'hA5, 8'h40, 8'h01, 8'h41, 0);
    idle(1);
    check("after timeout cfg", 64'(cfg), 64'(32'hFF3C0001));

    // A byte arriving in the cycle the timeout would fire wins.
    cnt_err = 0;
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h41);
    for (int t = 0; t < TIMEOUT - 1; t++) begin
      idle(1);
      if (frame_err) cnt_err++;
    end
    cycle(1'b1, 8'h10);
    if (frame_err) cnt_err++;
    cycle(1'b1, 8'h51);
    check("byte wins wr_pulse", 64'(wr_pulse), 64'(1'b1));
    check("byte wins no frame_err", 64'(cnt_err + int'(frame_err)), 64'(0));
    idle(1);
    check("byte wins cfg", 64'(cfg), 64'(32'hFF3C1001));
    check("byte wins ok_count", 64'(ok_count), 64'(8'd7));

    // Asynchronous reset in the middle of a frame.
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h43);
    #3 rst = 1'b1;
    #1;
    check("async rst busy", 64'(busy), 64'(1'b0));
    check("async rst cfg", 64'(cfg), 64'(32'h0));
    check("async rst ok_count", 64'(ok_count), 64'(8'h0));
    check("async rst frame_err", 64'(frame_err), 64'(1'b0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    send4(8'hA5, 8'h42, 8'h3C, 8'h7E, 1);
    idle(1);
    check("post rst frame cfg", 64'(cfg), 64'(32'h003C0000));

    // Saturation of ok_count.
    for (int i = 0; i < 256; i++) send4(8'hA5, 8'h00, 8'h00, 8'h00, 0);
    idle(1);
    check("ok_count saturates", 64'(ok_count), 64'(8'd255));

    // Random traffic against the model.
    for (int it = 0; it < 80; it++) begin
      kind = int'($urandom_range(0, 9));
      c = 8'($urandom);
      d = 8'($urandom);
      s = 8'($urandom);
      if (kind <= 5) begin
        c[7:6] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
        s = c + d;
      end else if (kind == 6) begin
        c[7:6] = 2'b01;
        s = c + d + 8'd1;
      end else if (kind == 7) begin
        c[7] = 1'b1;
        s = c + d;
      end else begin
        s = 8'($urandom);
      end
      if (kind == 9) begin
        cycle(1'b1, 8'hA5);
        cycle(1'b1, c);
        idle(int'($urandom_range(395, 405)));
      end else if (kind == 8) begin
        cycle(1'b1, c);
      end else begin
        send4(8'hA5, c, d, s, int'($urandom_range(0, 3)));
      end
      idle(int'($urandom_range(0, 50)));
    end
    idle(450);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
